// File: rtl/processor.sv
// processor: multi-cycle 16-bit core, four registers, one instruction per four steps on a shared bus.
module processor (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] iin,
  output logic [15:0] bus
);
  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
  step_t       step;
  logic [15:0] r [4];
  logic [15:0] ir, a, g, sext, alu;
  logic [3:0]  op;
  logic [1:0]  rx, ry;
  logic        is_ldi, is_rep, is_out, is_alu, wr_en;
  assign op     = ir[15:12];
  assign rx     = ir[11:10];
  assign ry     = ir[9:8];
  assign sext   = {{8{ir[7]}}, ir[7:0]};
  assign is_ldi = op == 4'h1;
  assign is_rep = op == 4'hE;
  assign is_out = op == 4'h8;
  assign is_alu = op >= 4'h2 && op <= 4'h6;
  assign wr_en  = (step == T1 && (is_ldi || is_rep)) || (step == T3 && is_alu);
  // bus is forced to zero while reset is held, even during the T0 fetch pass-through
  always_comb begin
    bus = 16'h0000;
    if (!resetn)
      bus = step == T0 ? iin :
            step == T1 ? (is_ldi ? sext : is_rep ? r[ry] : (is_alu || is_out) ? r[rx] : 16'h0000) :
            step == T2 ? (is_alu ? r[ry] : is_out ? r[rx] : 16'h0000) :
                         (is_alu ? g : is_out ? r[rx] : 16'h0000);
  end
  always_comb begin
    alu = op == 4'h2 ? a + bus :
          op == 4'h3 ? a + ~bus + 16'd1 :
          op == 4'h4 ? a & bus :
          op == 4'h5 ? a | bus : a ^ bus;
  end
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      step <= T0;
      ir   <= '0;
      a    <= '0;
      g    <= '0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      step <= step_t'(step + 2'd1);
      if (step == T0) ir <= iin;
      if (step == T1 && is_alu) a <= bus;
      if (step == T2 && is_alu) g <= alu;
      if (wr_en) r[rx] <= bus;
    end
  end
endmodule

// File: tb/tb_processor.sv
// tb_processor: directed instruction sequences with hand-computed bus values.
module tb_processor;
  logic        clock = 0;
  logic        resetn = 0;
  logic [15:0] iin = 16'h0000;
  logic [15:0] bus;
  logic [15:0] bt [4];
  int compared = 0;
  int mismatched = 0;

  processor dut (.clock(clock), .resetn(resetn), .iin(iin), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge in step T0; samples bus mid-cycle in each of T0..T3
  task automatic run(input logic [15:0] ins);
    iin = ins;
    #1 bt[0] = bus;
    for (int k = 1; k < 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      bt[k] = bus;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk3(input string tag, input logic [15:0] exp);
    for (int k = 1; k < 4; k++) chk($sformatf("%s_t%0d", tag, k), bt[k], exp);
  endtask

  initial begin
    iin = 16'h1234;
    @(negedge clock);
    resetn = 1;
    #1 chk("reset_bus_a", bus, 16'h0000);
    @(negedge clock);
    @(negedge clock);
    chk("reset_bus_b", bus, 16'h0000);
    resetn = 0;

    run(16'h8000); chk("fetch_pass", bt[0], 16'h8000); chk3("out_r0_reset", 16'h0000);

    run(16'h102A); chk("ldi_t1", bt[1], 16'h002A); chk("ldi_t2", bt[2], 16'h0000);
    run(16'hE400); chk("rep_t1", bt[1], 16'h002A);
    run(16'h8400); chk3("out_r1_42", 16'h002A);

    run(16'h18FF); run(16'h8800); chk3("sext_neg", 16'hFFFF);
    run(16'h1C7F); run(16'h8C00); chk3("sext_pos", 16'h007F);

    run(16'h10FF); run(16'h1401);
    run(16'h2100); chk("add_t1", bt[1], 16'hFFFF); chk("add_t2", bt[2], 16'h0001); chk("add_t3", bt[3], 16'h0000);
    run(16'h8000); chk3("add_wrap", 16'h0000);
    run(16'h3100); chk("sub_t3", bt[3], 16'hFFFF);
    run(16'h8000); chk3("sub_wrap", 16'hFFFF);

    run(16'h1078); run(16'h2000);
    run(16'h1440);
    for (int i = 0; i < 6; i++) run(16'h2500);
    run(16'h1801); run(16'h3600);
    run(16'h8400); chk("r1_0fff", bt[1], 16'h0FFF);
    run(16'hEC00); run(16'h4D00); run(16'h8C00); chk3("and", 16'h00F0);
    run(16'hEC00); run(16'h5D00); run(16'h8C00); chk3("or", 16'h0FFF);
    run(16'hEC00); run(16'h6D00); run(16'h8C00); chk3("xor", 16'h0F0F);

    run(16'h1005);
    iin = 16'h2000;
    @(posedge clock);
    @(negedge clock);
    chk("midop_t1", bus, 16'h0005);
    @(posedge clock);
    @(negedge clock);
    chk("midop_t2", bus, 16'h0005);
    resetn = 1;
    #1 chk("midop_reset", bus, 16'h0000);
    @(negedge clock);
    chk("midop_hold", bus, 16'h0000);
    resetn = 0;
    run(16'h8000); chk3("midop_r0", 16'h0000);

    run(16'h1409);
    run(16'hF123); chk3("illegal", 16'h0000);
    run(16'h0000); chk3("nop", 16'h0000);
    run(16'h8400); chk3("out_r1_9", 16'h0009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
